// File: rtl/unidade_controle_jogo_pkg.sv
// Shared encodings for the memory-game control unit. The datapath and the
// top level reuse these state codes when decoding db_estado.
package unidade_controle_jogo_pkg;

  localparam int ESTADO_W = 4;

  // Every 4-bit code is a real state, so no illegal encodings exist.
  typedef enum logic [ESTADO_W-1:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    EXIBE         = 4'h2,
    INICIA_RODADA = 4'h3,
    ESPERA        = 4'h4,
    REGISTRA      = 4'h5,
    COMPARA       = 4'h6,
    PROXIMA       = 4'h7,
    INCR_NOVA     = 4'h8,
    ESPERA_NOVA   = 4'h9,
    REGISTRA_NOVA = 4'hA,
    ESCREVE       = 4'hB,
    PROX_RODADA   = 4'hC,
    FIM_GANHOU    = 4'hD,
    FIM_PERDEU    = 4'hE,
    FIM_TIMEOUT   = 4'hF
  } estado_t;

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game. Sequences the datapath counters,
// play register and sequence memory, and reports the game outcome.
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       fimT,
  input  logic       fimTO,
  input  logic       cfg_timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraTO,
  output logic       contaTO,
  output logic       registraM,
  output logic       registraR,
  output logic       escreveM,
  output logic       mostra_inicial,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t prox_estado;

  // A timeout only counts when enabled; a simultaneous press always wins
  // because the press is tested first in the waiting states.
  logic expirou;
  assign expirou = fimTO && cfg_timeout;

  // State register with synchronous, top-priority reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox_estado;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns prox_estado and no latch is inferred.
    prox_estado = estado;
    case (estado)
      INICIAL:       if (jogar) prox_estado = PREPARA;
      PREPARA:       prox_estado = EXIBE;
      EXIBE:         if (fimT) prox_estado = INICIA_RODADA;
      INICIA_RODADA: prox_estado = ESPERA;
      ESPERA: begin
        if (tem_jogada)   prox_estado = REGISTRA;
        else if (expirou) prox_estado = FIM_TIMEOUT;
      end
      REGISTRA:      prox_estado = COMPARA;
      COMPARA: begin
        if (!igual)     prox_estado = FIM_PERDEU;
        else if (!fimE) prox_estado = PROXIMA;
        else if (fimL)  prox_estado = FIM_GANHOU;
        else            prox_estado = INCR_NOVA;
      end
      PROXIMA:       prox_estado = ESPERA;
      INCR_NOVA:     prox_estado = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (tem_jogada)   prox_estado = REGISTRA_NOVA;
        else if (expirou) prox_estado = FIM_TIMEOUT;
      end
      REGISTRA_NOVA: prox_estado = ESCREVE;
      ESCREVE:       prox_estado = PROX_RODADA;
      PROX_RODADA:   prox_estado = INICIA_RODADA;
      FIM_GANHOU,
      FIM_PERDEU,
      FIM_TIMEOUT:   if (jogar) prox_estado = PREPARA;
      default:       prox_estado = INICIAL;
    endcase
  end

  // Moore output decode: strobes depend only on the current state.
  always_comb begin
    zeraE          = 1'b0;
    contaE         = 1'b0;
    zeraL          = 1'b0;
    contaL         = 1'b0;
    zeraT          = 1'b0;
    contaT         = 1'b0;
    zeraTO         = 1'b0;
    contaTO        = 1'b0;
    registraM      = 1'b0;
    registraR      = 1'b0;
    escreveM       = 1'b0;
    mostra_inicial = 1'b0;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    timeout        = 1'b0;
    case (estado)
      PREPARA: begin
        zeraE     = 1'b1;
        zeraL     = 1'b1;
        zeraT     = 1'b1;
        zeraTO    = 1'b1;
        registraM = 1'b1;
      end
      EXIBE: begin
        contaT         = 1'b1;
        mostra_inicial = 1'b1;
      end
      INICIA_RODADA: begin
        zeraE  = 1'b1;
        zeraTO = 1'b1;
      end
      ESPERA, ESPERA_NOVA:     contaTO   = 1'b1;
      REGISTRA, REGISTRA_NOVA: registraR = 1'b1;
      PROXIMA, INCR_NOVA: begin
        contaE = 1'b1;
        zeraTO = 1'b1;
      end
      ESCREVE:     escreveM = 1'b1;
      PROX_RODADA: contaL   = 1'b1;
      FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        perdeu  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the memory-game control unit: walks the FSM through
// setup, rounds, win, loss, timeout and reset, checking state and strobes.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset, jogar, tem_jogada, igual, fimE, fimL, fimT, fimTO, cfg_timeout;
  logic       zeraE, contaE, zeraL, contaL, zeraT, contaT, zeraTO, contaTO;
  logic       registraM, registraR, escreveM, mostra_inicial;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  // Expected strobe vectors, bit order:
  // zeraE contaE zeraL contaL zeraT contaT zeraTO contaTO
  // registraM registraR escreveM mostra_inicial pronto ganhou perdeu timeout
  localparam logic [15:0] O_NONE  = 16'h0000;
  localparam logic [15:0] O_PREP  = 16'hAA80;
  localparam logic [15:0] O_EXIBE = 16'h0410;
  localparam logic [15:0] O_INIC  = 16'h8200;
  localparam logic [15:0] O_ESP   = 16'h0100;
  localparam logic [15:0] O_REG   = 16'h0040;
  localparam logic [15:0] O_PROX  = 16'h4200;
  localparam logic [15:0] O_ESCR  = 16'h0020;
  localparam logic [15:0] O_PRXR  = 16'h1000;
  localparam logic [15:0] O_GANH  = 16'h000C;
  localparam logic [15:0] O_PERD  = 16'h000A;
  localparam logic [15:0] O_TOUT  = 16'h000B;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL), .fimT(fimT), .fimTO(fimTO),
    .cfg_timeout(cfg_timeout),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraT(zeraT), .contaT(contaT), .zeraTO(zeraTO), .contaTO(contaTO),
    .registraM(registraM), .registraR(registraR), .escreveM(escreveM),
    .mostra_inicial(mostra_inicial), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [15:0] outs;
  assign outs = {zeraE, contaE, zeraL, contaL, zeraT, contaT, zeraTO, contaTO,
                 registraM, registraR, escreveM, mostra_inicial,
                 pronto, ganhou, perdeu, timeout};

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_st, input logic [15:0] exp_o);
    n_cmp++;
    assert (db_estado === exp_st)
    else begin
      n_err++;
      $error("FAIL %s state: observed %h expected %h", tag, db_estado, exp_st);
    end
    n_cmp++;
    assert (outs === exp_o)
    else begin
      n_err++;
      $error("FAIL %s outs: observed %h expected %h", tag, outs, exp_o);
    end
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; tem_jogada = 1'b0; igual = 1'b0;
    fimE = 1'b0; fimL = 1'b0; fimT = 1'b0; fimTO = 1'b0; cfg_timeout = 1'b0;
    step(); step();
    check("reset", 4'h0, O_NONE);
    reset = 1'b0;
    step();
    check("idle_hold", 4'h0, O_NONE);

    // Start game and wait through the display phase.
    jogar = 1'b1; step(); check("prepara", 4'h1, O_PREP);
    jogar = 1'b0; step(); check("exibe", 4'h2, O_EXIBE);
    step(); check("exibe_hold", 4'h2, O_EXIBE);
    fimT = 1'b1; step(); check("inicia", 4'h3, O_INIC);
    fimT = 1'b0; step(); check("espera", 4'h4, O_ESP);

    // Timeout disabled: fimTO ignored. jogar ignored mid-round.
    fimTO = 1'b1; step(); check("to_disabled", 4'h4, O_ESP);
    fimTO = 1'b0; jogar = 1'b1; step(); check("jogar_ignored", 4'h4, O_ESP);
    jogar = 1'b0;

    // Round with limit 0 complete -> add a new play.
    tem_jogada = 1'b1; step(); check("registra", 4'h5, O_REG);
    tem_jogada = 1'b0; igual = 1'b1; fimE = 1'b1; fimL = 1'b0;
    step(); check("compara", 4'h6, O_NONE);
    step(); check("incr_nova", 4'h8, O_PROX);
    step(); check("espera_nova", 4'h9, O_ESP);
    step(); check("espera_nova_hold", 4'h9, O_ESP);
    tem_jogada = 1'b1; step(); check("registra_nova", 4'hA, O_REG);
    tem_jogada = 1'b0; step(); check("escreve", 4'hB, O_ESCR);
    step(); check("prox_rodada", 4'hC, O_PRXR);
    step(); check("inicia2", 4'h3, O_INIC);
    step(); check("espera2", 4'h4, O_ESP);

    // Press and timeout together: press wins. Then mid-sequence match.
    cfg_timeout = 1'b1; fimTO = 1'b1; tem_jogada = 1'b1;
    step(); check("press_beats_to", 4'h5, O_REG);
    tem_jogada = 1'b0; fimTO = 1'b0; fimE = 1'b0; igual = 1'b1;
    step(); check("compara2", 4'h6, O_NONE);
    step(); check("proxima", 4'h7, O_PROX);
    step(); check("espera3", 4'h4, O_ESP);

    // Timeout enabled -> FIM_TIMEOUT, holds, then restart.
    fimTO = 1'b1; step(); check("fim_timeout", 4'hF, O_TOUT);
    fimTO = 1'b0; step(); check("fim_timeout_hold", 4'hF, O_TOUT);
    jogar = 1'b1; step(); check("restart_to", 4'h1, O_PREP);
    jogar = 1'b0; step();
    fimT = 1'b1; step(); fimT = 1'b0; step();
    check("espera4", 4'h4, O_ESP);

    // Mismatch -> FIM_PERDEU.
    tem_jogada = 1'b1; step();
    tem_jogada = 1'b0; igual = 1'b0; step();
    check("compara_miss", 4'h6, O_NONE);
    step(); check("fim_perdeu", 4'hE, O_PERD);
    jogar = 1'b1; step(); check("restart_perdeu", 4'h1, O_PREP);
    jogar = 1'b0; step();
    fimT = 1'b1; step(); fimT = 1'b0; step();

    // Last round complete -> FIM_GANHOU.
    tem_jogada = 1'b1; step();
    tem_jogada = 1'b0; igual = 1'b1; fimE = 1'b1; fimL = 1'b1; step();
    step(); check("fim_ganhou", 4'hD, O_GANH);
    step(); check("fim_ganhou_hold", 4'hD, O_GANH);
    jogar = 1'b1; step(); check("restart_ganhou", 4'h1, O_PREP);
    jogar = 1'b0; step();
    fimT = 1'b1; step(); fimT = 1'b0; step();
    check("espera5", 4'h4, O_ESP);

    // Two-cycle reset in ESPERA with other inputs active.
    reset = 1'b1; jogar = 1'b1; tem_jogada = 1'b1; fimTO = 1'b1;
    step(); check("reset_mid1", 4'h0, O_NONE);
    step(); check("reset_mid2", 4'h0, O_NONE);
    reset = 1'b0; jogar = 1'b0; tem_jogada = 1'b0; fimTO = 1'b0;
    step(); check("post_reset", 4'h0, O_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
